rpm_gate_controller: RTL
========================

// Module: rpm_gate_controller
// PURPOSE
//  Sequences the pulse counter for an RPM measurement: clears it, opens a fixed
//  gate window (count_en), closes it, latches count_in, scales it to RPM.
//  Sits between the Hall-sensor pulse counter and the display/readout logic.
//  Supports single-shot (start) and free-running (auto_mode) measurement.
// PARAMETERS
//  COUNT_W      4      width of count_in (matches pulse counter width)
//  GATE_CYCLES  50_000_000  clk cycles count_en is held high per window (>=1)
//  MULT_W       16     width of RPM_MULT
//  RPM_MULT     60     RPM per counted pulse = 60/(gate_s*pulses_per_rev)
//  RPM_W        COUNT_W+MULT_W (localparam, derived, not overridable)
// PORTS
//  clk        in   1        system clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  start      in   1        single-shot request, sampled in IDLE only
//  stop       in   1        abort; returns to IDLE from any state
//  auto_mode  in   1        1 = restart a new window after each result
//  count_in   in   COUNT_W  count value from pulse counter
//  count_en   out  1        gate to pulse counter; high only in GATE
//  done       out  1        1-cycle clear to pulse counter; high only in CLEAR
//  busy       out  1        high in every state except IDLE
//  rpm_out    out  RPM_W    last scaled result; holds between results
//  rpm_valid  out  1        1-cycle pulse when rpm_out updates
//  sat        out  1        result was taken with count_in all-ones; updates with rpm_valid
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; timer, latch, history 0.
//  FSM (all outputs registered, decoded from state):
//   IDLE  : (start|auto_mode)&~stop -> CLEAR
//   CLEAR : done=1 for one cycle -> GATE; timer<=0
//   GATE  : count_en=1; timer++; at timer==GATE_CYCLES-1 -> LATCH
//           (count_en high exactly GATE_CYCLES cycles)
//   LATCH : count_en=0; cnt_q<=count_in; sat_n<=(count_in=={COUNT_W{1'b1}}) -> SCALE
//   SCALE : rpm_out<=cnt_q*RPM_MULT (full RPM_W product, no truncation);
//           rpm_valid=1 and sat<=sat_n that cycle; -> CLEAR if auto_mode else IDLE
//  Latency: start sampled in IDLE -> done cycle 1 -> count_en cycles 2..GATE_CYCLES+1
//   -> rpm_valid at cycle GATE_CYCLES+3.
//  stop has priority over everything: next state IDLE; no rpm_valid; rpm_out/sat
//   hold their previous values; done is not issued. Counter is cleared by the next CLEAR.
//  start and stop in the same cycle: stays IDLE. start while busy: ignored.
//  auto_mode dropped mid-window: current window completes, then IDLE.
//  count_in==0: rpm_out=0, rpm_valid=1, sat=0.
//  rst_n asserted mid-window: immediate IDLE and outputs 0; no partial result.
// CONFIGURATION
//  RPM_AVG_EN defined: rpm_out = (cur+prev)>>1, RPM_W+1-bit sum, floor. prev is the
//   previous scaled result. First result after reset or stop is cur alone
//   (prev_valid flag cleared by reset and stop). Latency is unchanged.
//  RPM_AVG_EN undefined: rpm_out = cur. No history registers are built.
// STRUCTURE
//  Shared package rpm_pkg: state enum (IDLE,CLEAR,GATE,LATCH,SCALE), state width,
//   sat-detect helper constant.
//  One sub-module, rpm_gate_timer: a load/enable cycle counter with a terminal-count
//   flag, sized $clog2(GATE_CYCLES).
// TESTING (bench: GATE_CYCLES=8, RPM_MULT=100, COUNT_W=4, behavioural counter model)
//  1 reset: rst_n=0 -> count_en=0, done=0, busy=0, rpm_out=0, rpm_valid=0, sat=0
//  2 single shot: start pulse, 5 edges in window -> done 1 cycle, count_en exactly
//    8 cycles, rpm_out=500, rpm_valid at cycle 11, then IDLE, busy=0
//  3 saturation: count_in=15 at LATCH -> rpm_out=1500, sat=1; next window count 2 -> sat=0
//  4 auto_mode=1, counts 3 then 7 -> rpm 300 then 700 (RPM_AVG_EN: 300 then 500);
//    done precedes every window
//  5 stop at GATE cycle 4 -> count_en=0 next cycle, no rpm_valid, rpm_out holds 500
//  6 start&stop same cycle -> stays IDLE; start during GATE ignored; count 0 -> rpm_out=0

Source files
------------

// File: rtl/rpm_pkg.sv
// Shared types and constants for the RPM gate controller and its gate timer.
package rpm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        GATE  = 3'd2,
        LATCH = 3'd3,
        SCALE = 3'd4
    } state_t;

    // Fill bit for the all-ones saturation pattern of count_in.
    localparam logic SAT_FILL = 1'b1;

endpackage

// File: rtl/rpm_gate_timer.sv
// Gate window timer: loads GATE_CYCLES-1, counts down while enabled,
// and flags terminal count at zero.
module rpm_gate_timer
    import rpm_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TW-1:0] LOAD_VAL = TW'(GATE_CYCLES - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/rpm_gate_controller.sv
// RPM measurement sequencer: clear counter, open gate window, latch, scale.
// Define RPM_AVG_EN to average each result with the previous one.
//
//  state | meaning
//  IDLE  | waiting for start or auto_mode
//  CLEAR | done pulse clears the external pulse counter, timer loaded
//  GATE  | count_en high for GATE_CYCLES cycles
//  LATCH | gate closed, count_in settled and captured
//  SCALE | rpm_valid pulse with the new result
module rpm_gate_controller
    import rpm_pkg::*;
#(
    parameter int COUNT_W     = 4,
    parameter int GATE_CYCLES = 50_000_000,
    parameter int MULT_W      = 16,
    parameter int RPM_MULT    = 60
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       auto_mode,
    input  logic [COUNT_W-1:0]         count_in,
    output logic                       count_en,
    output logic                       done,
    output logic                       busy,
    output logic [COUNT_W+MULT_W-1:0]  rpm_out,
    output logic                       rpm_valid,
    output logic                       sat
);

    localparam int RPM_W = COUNT_W + MULT_W;
    localparam logic [MULT_W-1:0] MULT = MULT_W'(RPM_MULT);

    state_t state;
    state_t next;
    logic   tc;
    logic   publish;
    logic   sat_n;
    logic [RPM_W-1:0] cur;
    logic [RPM_W-1:0] result;

    rpm_gate_timer #(
        .GATE_CYCLES (GATE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == CLEAR),
        .en    (state == GATE),
        .tc    (tc)
    );

    always_comb begin
        next = state;
        case (state)
            IDLE:    if ((start || auto_mode) && !stop) next = CLEAR;
            CLEAR:   next = GATE;
            GATE:    if (tc) next = LATCH;
            LATCH:   next = SCALE;
            SCALE:   next = auto_mode ? CLEAR : IDLE;
            default: next = IDLE;
        endcase
        if (stop) next = IDLE;
    end

    // Result is published on the LATCH->SCALE edge so rpm_valid and rpm_out
    // appear together in the SCALE cycle.
    assign publish = (state == LATCH) && (next == SCALE);
    assign cur     = RPM_W'(count_in) * RPM_W'(MULT);
    assign sat_n   = (count_in == {COUNT_W{SAT_FILL}});

`ifdef RPM_AVG_EN
    logic [RPM_W-1:0] prev_q;
    logic             prev_valid;
    logic [RPM_W:0]   sum;

    assign sum    = {1'b0, cur} + {1'b0, prev_q};
    assign result = prev_valid ? RPM_W'(sum >> 1) : cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            prev_valid <= 1'b0;
        end else if (stop) begin
            prev_valid <= 1'b0;
        end else if (publish) begin
            prev_q     <= cur;
            prev_valid <= 1'b1;
        end
    end
`else
    assign result = cur;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count_en  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            rpm_valid <= 1'b0;
            rpm_out   <= '0;
            sat       <= 1'b0;
        end else begin
            state     <= next;
            count_en  <= (next == GATE);
            done      <= (next == CLEAR);
            busy      <= (next != IDLE);
            rpm_valid <= publish;
            if (publish) begin
                rpm_out <= result;
                sat     <= sat_n;
            end
        end
    end

endmodule
